// File: rtl/ma_result_fifo.sv
// Result FIFO behind the moving-average filter: first-word-fall-through
// storage with drop-on-full accounting and a valid/ready consumer port.
module ma_result_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_pulse,
    input  logic                  flush,
    input  logic                  clear_overflow,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr;
    logic                  rd;
    logic                  full;
    logic                  accept;
    logic                  drop;

    assign m_valid = (level != '0);
    assign m_data  = mem[rd_ptr];

    // Handshake qualifiers; a flush swallows the concurrent sample silently.
    always_comb begin
        wr     = enable & in_pulse;
        rd     = m_valid & m_ready;
        full   = (level == FULL_LVL);
        accept = wr & (!full | rd) & !flush;
        drop   = wr & full & !rd & !flush;
    end

    // Sample storage, zeroed on reset so the head reads 0 while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; simultaneous write and pop leave level as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd)     rd_ptr <= rd_ptr + PTR_ONE;
            if (accept && !rd)      level <= level + LVL_ONE;
            else if (!accept && rd) level <= level - LVL_ONE;
        end
    end

    // Drop accounting; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow)           drop_count <= 8'd1;
            else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_ma_result_fifo.sv
// Bench for ma_result_fifo: directed scenarios plus random traffic
// compared against a queue-based model of the buffer.
module tb_ma_result_fifo;

    localparam int DW  = 16;
    localparam int DL2 = 3;
    localparam int DEP = 1 << DL2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_pulse = 1'b0;
    logic          flush = 1'b0;
    logic          clear_overflow = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DL2:0]  level;
    logic          overflow;
    logic [7:0]    drop_count;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf = 0;
    int            m_dcnt = 0;

    ma_result_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_data(in_data),
        .in_pulse(in_pulse), .flush(flush), .clear_overflow(clear_overflow),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("m_valid", 32'(m_valid), 32'(q.size() != 0));
        check("level", 32'(level), 32'(q.size()));
        if (q.size() != 0) check("m_data", 32'(m_data), 32'(q[0]));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_count", 32'(drop_count), 32'(m_dcnt));
    endtask

    // One clock: model the edge from the rules, then compare 1 time unit later.
    task automatic step();
        bit wr, rd, full, drop;
        wr   = enable && in_pulse;
        rd   = (q.size() != 0) && m_ready;
        full = (q.size() == DEP);
        drop = wr && full && !rd && !flush;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (rd) void'(q.pop_front());
            if (wr && (!full || rd)) q.push_back(in_data);
        end
        if (drop) begin
            m_ovf  = 1;
            m_dcnt = clear_overflow ? 1 : (m_dcnt < 255 ? m_dcnt + 1 : 255);
        end else if (clear_overflow) begin
            m_ovf  = 0;
            m_dcnt = 0;
        end
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        in_pulse = 0; flush = 0; clear_overflow = 0; enable = 1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_pulse = 1; in_data = d;
        step();
        in_pulse = 0;
    endtask

    task automatic drain();
        m_ready = 1; in_pulse = 0;
        for (int i = 0; i < DEP + 2; i++) step();
    endtask

    task automatic check_reset_outputs();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
    endtask

    initial begin
        int peak;
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Basic order with a ready consumer
        m_ready = 1;
        peak = 0;
        push(16'h0001);
        if (level > peak) peak = level;
        push(16'h7FFF);
        if (level > peak) peak = level;
        push(16'h8000);
        if (level > peak) peak = level;
        step();
        check("basic_peak", 32'(peak), 32'd1);
        check("basic_empty", 32'(m_valid), 32'd0);

        // Fill and drop
        m_ready = 0;
        for (int i = 1; i <= 10; i++) push(DW'(i));
        check("fill_level", 32'(level), 32'd8);
        check("fill_ovf", 32'(overflow), 32'd1);
        check("fill_drops", 32'(drop_count), 32'd2);
        check("fill_head", 32'(m_data), 32'd1);
        drain();

        // Full with simultaneous pop and write
        clear_overflow = 1; step(); clear_overflow = 0;
        m_ready = 0;
        for (int i = 0; i < DEP; i++) push(DW'(16'h100 + i));
        m_ready = 1;
        push(16'h1234);
        check("fpw_level", 32'(level), 32'd8);
        check("fpw_drops", 32'(drop_count), 32'd0);
        m_ready = 1;
        for (int i = 0; i < DEP - 1; i++) step();
        check("fpw_last", 32'(m_data), 32'h1234);
        step();

        // Flush beats a concurrent write
        m_ready = 0;
        for (int i = 0; i < 5; i++) push(DW'(16'h200 + i));
        flush = 1; in_pulse = 1; in_data = 16'hDEAD;
        step();
        idle_inputs();
        check("flush_level", 32'(level), 32'd0);
        check("flush_valid", 32'(m_valid), 32'd0);
        check("flush_drops", 32'(drop_count), 32'd0);

        // Clear concurrent with a drop
        for (int i = 0; i < DEP + 3; i++) push(DW'(16'h300 + i));
        clear_overflow = 1; in_pulse = 1; in_data = 16'hBEEF;
        step();
        idle_inputs();
        check("clrdrop_ovf", 32'(overflow), 32'd1);
        check("clrdrop_cnt", 32'(drop_count), 32'd1);

        // Saturation
        for (int i = 0; i < 300; i++) push(DW'($urandom));
        check("sat_cnt", 32'(drop_count), 32'd255);

        // Enable low: pulses ignored while draining
        enable = 0; in_pulse = 1; m_ready = 1;
        for (int i = 0; i < DEP + 2; i++) begin
            in_data = DW'($urandom);
            step();
        end
        check("en_level", 32'(level), 32'd0);
        check("en_cnt", 32'(drop_count), 32'd255);
        idle_inputs();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            enable         = ($urandom_range(0, 9) != 0);
            in_pulse       = $urandom_range(0, 1);
            in_data        = DW'($urandom);
            m_ready        = ($urandom_range(0, 9) < 4);
            flush          = ($urandom_range(0, 49) == 0);
            clear_overflow = ($urandom_range(0, 29) == 0);
            step();
        end
        idle_inputs();

        // Reset mid-stream
        flush = 1; step(); flush = 0;
        m_ready = 0;
        for (int i = 0; i < 4; i++) push(DW'(16'h400 + i));
        check("pre_rst_level", 32'(level), 32'd4);
        rst_n = 0;
        #1;
        q.delete(); m_ovf = 0; m_dcnt = 0;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1;
        push(16'hA5A5);
        check("post_rst_valid", 32'(m_valid), 32'd1);
        check("post_rst_data", 32'(m_data), 32'hA5A5);
        m_ready = 1; step();
        check("post_rst_pop", 32'(m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
